// File: rtl/gate_truth_sequencer_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
package gate_seq_pkg;

  localparam int unsigned VEC_COUNT = 4;
  localparam int unsigned VEC_IDX_W = 2;
  localparam int unsigned CNT_W     = 4;

  // Expected-output tables, bit i = gate output for {a,b} == i
  localparam logic [VEC_COUNT-1:0] TT_AND  = 4'b1000;
  localparam logic [VEC_COUNT-1:0] TT_OR   = 4'b1110;
  localparam logic [VEC_COUNT-1:0] TT_XOR  = 4'b0110;
  localparam logic [VEC_COUNT-1:0] TT_NAND = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    DONE
  } gate_seq_state_t;

endpackage

// File: rtl/gate_truth_sequencer_if.sv
// Start/done handshake plus gate-under-test pins for the sequencer.
interface gate_truth_sequencer_if;
  import gate_seq_pkg::*;

  logic                 start;
  logic                 gate_a;
  logic                 gate_b;
  logic                 gate_s;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [VEC_COUNT-1:0] fail_mask;
  logic [VEC_IDX_W-1:0] vec_idx;

  // Requester / gate side
  modport master (
    output start,
    input  gate_a, gate_b, gate_s, busy, done, pass, fail_mask, vec_idx
  );

  // Sequencer side
  modport slave (
    input  start, gate_s,
    output gate_a, gate_b, busy, done, pass, fail_mask, vec_idx
  );

endinterface

// File: rtl/gate_truth_sequencer_settle_timer.sv
// Loadable 4-bit down-counter that flags when the settle wait is on its last cycle.
module gate_seq_settle_timer
  import gate_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Next count: load wins over decrement, counter saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    expired_d = (cnt_d == CNT_W'(1));
  end

  // Counter and registered expiry flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/gate_truth_sequencer.sv
// Sweeps a 2-input gate through all four input vectors and checks it against EXP_TT.
// Optional build macro GATE_SEQ_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module gate_truth_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned          SETTLE_CYCLES = 1,
  parameter logic [VEC_COUNT-1:0] EXP_TT        = TT_AND
) (
  input logic                   clk,
  input logic                   reset,
  gate_truth_sequencer_if.slave bus
);

  gate_seq_state_t      state_q, state_d;
  logic [VEC_IDX_W-1:0] vec_idx_q, vec_idx_d;
  logic [VEC_COUNT-1:0] fail_mask_q, fail_mask_d;
  logic                 gate_a_q, gate_a_d;
  logic                 gate_b_q, gate_b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 tmr_load, tmr_en, tmr_expired;
  logic                 mismatch, last_vec, finish;

  gate_seq_settle_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (CNT_W'(SETTLE_CYCLES)),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  // Sweep control; gate pins are loaded on entry to DRIVE so the vector is live during DRIVE
  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    fail_mask_d = fail_mask_q;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    mismatch    = 1'b0;
    last_vec    = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = DRIVE;
          vec_idx_d   = '0;
          fail_mask_d = '0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          gate_a_d    = 1'b0;
          gate_b_d    = 1'b0;
        end
      end
      DRIVE: begin
        tmr_load = 1'b1;
        state_d  = (SETTLE_CYCLES == 0) ? SAMPLE : WAIT;
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (tmr_expired) state_d = SAMPLE;
      end
      SAMPLE: begin
        // Case inequality so an X/Z gate output also counts as a failure
        mismatch = (bus.gate_s !== EXP_TT[vec_idx_q]);
        if (mismatch) fail_mask_d[vec_idx_q] = 1'b1;
        last_vec = (vec_idx_q == VEC_IDX_W'(VEC_COUNT - 1));
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        finish = last_vec || mismatch;
`else
        finish = last_vec;
`endif
        if (finish) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_mask_d == '0);
        end else begin
          state_d   = DRIVE;
          vec_idx_d = vec_idx_q + VEC_IDX_W'(1);
          gate_a_d  = vec_idx_d[1];
          gate_b_d  = vec_idx_d[0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vec_idx_q   <= '0;
      fail_mask_q <= '0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      fail_mask_q <= fail_mask_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.gate_a    = gate_a_q;
  assign bus.gate_b    = gate_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_mask_q;
  assign bus.vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench: three sequencers (AND/settle 1, OR/settle 1, AND/settle 0) each facing an AND gate.
module tb_gate_truth_sequencer;
  import gate_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  gate_truth_sequencer_if if0 ();
  gate_truth_sequencer_if if1 ();
  gate_truth_sequencer_if if2 ();

  // Behavioural AND gates under test
  assign if0.gate_s = if0.gate_a & if0.gate_b;
  assign if1.gate_s = if1.gate_a & if1.gate_b;
  assign if2.gate_s = if2.gate_a & if2.gate_b;

  gate_truth_sequencer #(.SETTLE_CYCLES(1), .EXP_TT(TT_AND)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  gate_truth_sequencer #(.SETTLE_CYCLES(1), .EXP_TT(TT_OR)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  gate_truth_sequencer #(.SETTLE_CYCLES(0), .EXP_TT(TT_AND)) dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start all three sequencers together; k counts edges with the accepting edge as 1
  task automatic run_sweep(input string pfx);
    if0.start = 1'b1;
    if1.start = 1'b1;
    if2.start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) begin
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
      end
      if (k <= 12) begin
        check({pfx, "_and_vec"}, 16'({if0.gate_a, if0.gate_b}), 16'((k - 1) / 3));
        check({pfx, "_and_idx"}, 16'(if0.vec_idx), 16'((k - 1) / 3));
        check({pfx, "_and_busy_done"}, 16'({if0.busy, if0.done}), 16'b10);
      end
      if (k <= 8) begin
        check({pfx, "_s0_idx"}, 16'(if2.vec_idx), 16'((k - 1) / 2));
        check({pfx, "_s0_busy_done"}, 16'({if2.busy, if2.done}), 16'b10);
      end
      if (k == 9) begin
        check({pfx, "_s0_done"}, 16'({if2.busy, if2.done, if2.pass}), 16'b011);
        check({pfx, "_s0_mask"}, 16'(if2.fail_mask), 16'h0);
      end
      if (k == 10) check({pfx, "_s0_done_pulse"}, 16'(if2.done), 16'h0);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
      if (k == 7) begin
        check({pfx, "_or_stop_done"}, 16'({if1.busy, if1.done, if1.pass}), 16'b010);
        check({pfx, "_or_stop_mask"}, 16'(if1.fail_mask), 16'b0010);
        check({pfx, "_or_stop_idx"}, 16'(if1.vec_idx), 16'h1);
      end
`else
      if (k == 12) check({pfx, "_or_pre_done"}, 16'(if1.done), 16'h0);
      if (k == 13) begin
        check({pfx, "_or_done"}, 16'({if1.busy, if1.done, if1.pass}), 16'b010);
        check({pfx, "_or_mask"}, 16'(if1.fail_mask), 16'b0110);
      end
`endif
      if (k == 13) begin
        check({pfx, "_and_done"}, 16'({if0.busy, if0.done, if0.pass}), 16'b011);
        check({pfx, "_and_mask"}, 16'(if0.fail_mask), 16'h0);
      end
      if (k == 14) begin
        check({pfx, "_and_hold"}, 16'({if0.done, if0.pass, if0.gate_a, if0.gate_b}), 16'b0111);
        check({pfx, "_or_hold"}, 16'({if1.done, if1.pass}), 16'b00);
      end
    end
  endtask

  initial begin
    int ndone;
    reset     = 1'b1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;
    #2;
    check("reset_outs", 16'({if0.gate_a, if0.gate_b, if0.busy, if0.done, if0.pass,
                             if0.fail_mask, if0.vec_idx}), 16'h0);
    #6 reset = 1'b0;
    step();
    step();
    check("idle_no_start", 16'({if0.busy, if0.done}), 16'h0);

    run_sweep("sw1");

    // Reset asynchronously while dut0 is in the WAIT of vector 2
    if0.start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) if0.start = 1'b0;
    end
    check("pre_reset_vec2", 16'({if0.gate_a, if0.gate_b, if0.busy}), 16'b101);
    #3 reset = 1'b1;
    #1;
    check("midrst_outs", 16'({if0.gate_a, if0.gate_b, if0.busy, if0.done, if0.pass,
                              if0.fail_mask, if0.vec_idx}), 16'h0);
    check("midrst_or_mask", 16'(if1.fail_mask), 16'h0);
    #2 reset = 1'b0;
    step();

    run_sweep("sw2");

    // Start held through the sweep and into the DONE cycle: one sweep only
    ndone     = 0;
    if0.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (if0.done) ndone++;
      if (k == 13) check("held_done", 16'(if0.done), 16'h1);
      if (k == 14) if0.start = 1'b0;
      if (k == 15) check("held_no_restart", 16'({if0.busy, if0.done}), 16'h0);
    end
    check("held_done_count", 16'(ndone), 16'h1);
    check("held_idle", 16'({if0.busy, if0.pass, if0.fail_mask}), 16'b010000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
